// File: rtl/uf7_to_fixed_if.sv
`default_nettype none
// ============================================================================
//  Module      : uf7_to_fixed_if
//  Description : Float-in / fixed-out handshake bundle for uf7_to_fixed.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uf7_to_fixed_if #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
);
    localparam int OUT_W = MAN_W + 2**EXP_W;

    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+MAN_W-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_data;
    logic                   busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/uf7_to_fixed.sv
`default_nettype none
// ============================================================================
//  Module      : uf7_to_fixed
//  Description : Sequential uf7 {exp,man} to unsigned fixed-point expander,
//                one left shift per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module uf7_to_fixed #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    uf7_to_fixed_if.slave   bus
);
    localparam int OUT_W   = MAN_W + 2**EXP_W;
    localparam int c_PAD_W = OUT_W - MAN_W - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_sh;
    logic [EXP_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [OUT_W-1:0]   r_out_data;

    logic [EXP_W-1:0]   w_exp;
    logic [MAN_W-1:0]   w_man;
    logic [OUT_W-1:0]   w_man_ext;
    logic [OUT_W-1:0]   w_sh_next;

    assign w_exp     = bus.in_data[EXP_W+MAN_W-1 -: EXP_W];
    assign w_man     = bus.in_data[MAN_W-1:0];
    assign w_man_ext = {{c_PAD_W{1'b0}}, 1'b1, w_man};
    assign w_sh_next = r_sh << 1;

    // Outputs are flopped alongside the state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sh       <= w_man_ext;
                        r_cnt      <= w_exp;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_exp == '0) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_man_ext;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == EXP_W'(1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sh_next;
                    end
                end
                S_DONE: begin
                    // No same-cycle reload: a new float waits for the next IDLE cycle.
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_out_data  <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_out_data  <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_uf7_to_fixed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uf7_to_fixed
//  Description : Self-checking bench for uf7_to_fixed against a value model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uf7_to_fixed;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    uf7_to_fixed_if #(.EXP_W(3), .MAN_W(4)) bus ();

    uf7_to_fixed #(.EXP_W(3), .MAN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Value of a uf7 code in units of 2^-7: 1.man * 2^(exp-3) * 2^7.
    function automatic int ref_val(input logic [6:0] code);
        int e;
        int m;
        e = int'(code[6:4]);
        m = int'(code[3:0]);
        return (16 + m) * (1 << e);
    endfunction

    // Called just after a negedge; returns after the accepting posedge.
    task automatic accept(input logic [6:0] code);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = code;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 20);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid actual=%b required=0", bus.out_valid);
        else n_pass++;
        n_total++;
        if (bus.out_data !== 12'h000) $display("FAIL reset_out_data actual=%h required=000", bus.out_data);
        else n_pass++;
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy actual=%b required=0", bus.busy);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready actual=%b required=1", bus.in_ready);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL idle_after_reset actual=rdy%b busy%b vld%b required=rdy1 busy0 vld0",
                     bus.in_ready, bus.busy, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [6:0] codes [7];
        int lat;
        codes[0] = 7'b100_1000;
        codes[1] = 7'b100_1100;
        codes[2] = 7'b000_0000;
        for (int i = 3; i < 7; i++) codes[i] = 7'($urandom);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            accept(codes[i]);
            wait_valid(lat);
            n_total++;
            if (lat != int'(codes[i][6:4]) + 1)
                $display("FAIL basic_latency code=%h actual=%0d required=%0d", codes[i], lat, int'(codes[i][6:4]) + 1);
            else n_pass++;
            n_total++;
            if (int'(bus.out_data) != ref_val(codes[i]))
                $display("FAIL basic_data code=%h actual=%h required=%h", codes[i], bus.out_data, ref_val(codes[i]));
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_data !== 12'h000)
                $display("FAIL basic_pulse_end code=%h actual=vld%b rdy%b busy%b data%h required=vld0 rdy1 busy0 data000",
                         codes[i], bus.out_valid, bus.in_ready, bus.busy, bus.out_data);
            else n_pass++;
        end
    endtask

    task automatic test_max();
        int lat;
        int shifts;
        bus.out_ready = 1'b1;
        accept(7'b111_1111);
        lat = 0;
        shifts = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy && !bus.out_valid) shifts++;
        end while (!bus.out_valid && lat < 20);
        n_total++;
        if (lat != 8) $display("FAIL max_latency actual=%0d required=8", lat);
        else n_pass++;
        n_total++;
        if (shifts != 7) $display("FAIL max_shift_cycles actual=%0d required=7", shifts);
        else n_pass++;
        n_total++;
        if (bus.out_data !== 12'hF80) $display("FAIL max_data actual=%h required=f80", bus.out_data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready = 1'b0;
        accept(7'b011_0101);
        wait_valid(lat);
        n_total++;
        if (lat != 4 || bus.out_data !== 12'h0A8)
            $display("FAIL bp_first actual=lat%0d data%h required=lat4 data0a8", lat, bus.out_data);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_data  = 7'($urandom);
            @(negedge clk);
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 12'h0A8 || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold cycle=%0d actual=vld%b data%h rdy%b required=vld1 data0a8 rdy0",
                         i, bus.out_valid, bus.out_data, bus.in_ready);
            else n_pass++;
        end
        bus.in_valid  = 1'b0;
        bus.in_data   = 'x;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL bp_release actual=vld%b rdy%b busy%b required=vld0 rdy1 busy0",
                     bus.out_valid, bus.in_ready, bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        bus.out_ready = 1'b1;
        accept(7'b110_0001);
        repeat (2) @(negedge clk);
        n_total++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL rst_mid_pre actual=busy%b vld%b required=busy1 vld0", bus.busy, bus.out_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 12'h000 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL rst_mid_async actual=vld%b data%h rdy%b busy%b required=vld0 data000 rdy1 busy0",
                     bus.out_valid, bus.out_data, bus.in_ready, bus.busy);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept(7'b001_0000);
        wait_valid(lat);
        n_total++;
        if (lat != 2 || bus.out_data !== 12'h020)
            $display("FAIL rst_mid_after actual=lat%0d data%h required=lat2 data020", lat, bus.out_data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [6:0]  order [128];
        logic [6:0]  tmp;
        logic [11:0] got [$];
        int idx;
        int cycles;
        int j;
        int nbad;
        for (int i = 0; i < 128; i++) order[i] = 7'(i);
        for (int i = 127; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        idx = 0;
        cycles = 0;
        while (got.size() < 128 && cycles < 4000) begin
            if (idx < 128) begin
                bus.in_valid = 1'b1;
                bus.in_data  = order[idx];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 'x;
            end
            bus.out_ready = ($urandom_range(3, 0) != 0);
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            @(negedge clk);
            cycles++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_total++;
        if (got.size() != 128) $display("FAIL sweep_count actual=%0d required=128", got.size());
        else n_pass++;
        nbad = 0;
        for (int i = 0; i < got.size(); i++) begin
            n_total++;
            if (int'(got[i]) != ref_val(order[i])) begin
                if (nbad < 10)
                    $display("FAIL sweep_data idx=%0d code=%h actual=%h required=%h",
                             i, order[i], got[i], ref_val(order[i]));
                nbad++;
            end else n_pass++;
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
